// File: rtl/count_seq_unit_if.sv
// count_seq_unit_if: handshake/bus bundle for count_seq_unit.
//   master : run requester and output consumer (drives start, limit, out_ready)
//   slave  : the counting sequencer (drives out_valid, out_data, busy, done, sum)
//   start     - run request, honoured only while the sequencer is idle
//   limit     - exclusive upper bound, captured with an accepted start
//   out_ready - consumer ready for out_data
//   out_valid - out_data carries a valid count
//   out_data  - current count value
//   busy      - sequencer is not idle
//   done      - one-cycle end-of-run pulse
//   sum       - running sum of emitted values (constant 0 unless enabled)
interface count_seq_unit_if #(
    parameter int unsigned WIDTH = 8
);
    logic                 start;
    logic [WIDTH-1:0]     limit;
    logic                 out_ready;
    logic                 out_valid;
    logic [WIDTH-1:0]     out_data;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   sum;

    modport master (
        output start, limit, out_ready,
        input  out_valid, out_data, busy, done, sum
    );

    modport slave (
        input  start, limit, out_ready,
        output out_valid, out_data, busy, done, sum
    );
endinterface

// File: rtl/count_seq_unit.sv
// count_seq_unit: on an accepted start, emits 0, STEP, 2*STEP, ... while the
// count stays below the captured limit and does not overflow WIDTH bits, each
// value offered on a valid/ready handshake, then pulses done once.
// Ports:
//   clk     - clock, all state updates on its rising edge
//   reset   - synchronous active-high reset, aborts any run without done
//   port_if - count_seq_unit_if.slave (start, limit, out_ready in;
//             out_valid, out_data, busy, done, sum out)
// Parameters: WIDTH (2..32) counter/limit width, STEP (1..2^WIDTH-1) increment.
// Optional feature: define COUNT_SEQ_SUM_EN to build the running-sum
// accumulator; without it sum is tied to 0 and no accumulator exists.
module count_seq_unit #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned STEP  = 1
) (
    input  logic               clk,
    input  logic               reset,
    count_seq_unit_if.slave    port_if
);
    localparam int unsigned    SUM_W  = 2 * WIDTH;
    localparam logic [WIDTH-1:0] STEP_V = WIDTH'(STEP);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CMP  = 3'd1,
        S_OUT  = 3'd2,
        S_INC  = 3'd3,
        S_DONE = 3'd4
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   lim_q, lim_d;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   out_data_q, out_data_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [WIDTH:0]     inc_c;
    logic               hs_c;
    logic               accept_c;

    // Extra top bit of the increment is the carry that ends the run.
    assign inc_c    = {1'b0, a_q} + {1'b0, STEP_V};
    assign hs_c     = (state_q == S_OUT) && port_if.out_ready;
    assign accept_c = (state_q == S_IDLE) && port_if.start;

    // Next-state and next-output logic; outputs are decoded from the next
    // state so they register in the same edge as the state itself.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        lim_d   = lim_q;
        case (state_q)
            S_IDLE: begin
                if (port_if.start) begin
                    lim_d   = port_if.limit;
                    a_d     = '0;
                    state_d = S_CMP;
                end
            end
            S_CMP: begin
                state_d = (a_q < lim_q) ? S_OUT : S_DONE;
            end
            S_OUT: begin
                if (hs_c) begin
                    state_d = S_INC;
                end
            end
            S_INC: begin
                a_d     = inc_c[WIDTH-1:0];
                state_d = inc_c[WIDTH] ? S_DONE : S_CMP;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        out_valid_d = (state_d == S_OUT);
        out_data_d  = out_valid_d ? a_d : '0;
        busy_d      = (state_d != S_IDLE);
        done_d      = (state_d == S_DONE);
    end

    // State, datapath and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            lim_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            lim_q       <= lim_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign port_if.out_valid = out_valid_q;
    assign port_if.out_data  = out_data_q;
    assign port_if.busy      = busy_q;
    assign port_if.done      = done_q;

`ifdef COUNT_SEQ_SUM_EN
    logic [SUM_W-1:0] sum_q, sum_d;

    // Cleared on an accepted start, accumulates each handshaken value and
    // otherwise holds so the last run's total stays readable while idle.
    always_comb begin
        sum_d = sum_q;
        if (accept_c) begin
            sum_d = '0;
        end else if (hs_c) begin
            sum_d = sum_q + SUM_W'(a_q);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign port_if.sum = sum_q;
`else
    logic unused_accept;
    assign unused_accept = accept_c;
    assign port_if.sum   = SUM_W'(0);
`endif

endmodule

// File: tb/tb_count_seq_unit.sv
// Scoreboard bench for count_seq_unit. Two instances: A (WIDTH=8, STEP=1) and
// B (WIDTH=4, STEP=6, exercises the overflow-terminated run). Each run pushes
// the expected values, sum and (when out_ready is held high) cycle timing
// into per-instance queues; a negedge monitor pops and compares.
module tb_count_seq_unit;
    localparam int unsigned WA = 8;
    localparam int unsigned SA = 1;
    localparam int unsigned WB = 4;
    localparam int unsigned SB = 6;
    localparam logic [63:0] NO_T = '1;
`ifdef COUNT_SEQ_SUM_EN
    localparam bit SUM_ON = 1'b1;
`else
    localparam bit SUM_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    count_seq_unit_if #(.WIDTH(WA)) bus_a ();
    count_seq_unit_if #(.WIDTH(WB)) bus_b ();

    count_seq_unit #(.WIDTH(WA), .STEP(SA)) u_dut_a (
        .clk     (clk),
        .reset   (reset),
        .port_if (bus_a.slave)
    );

    count_seq_unit #(.WIDTH(WB), .STEP(SB)) u_dut_b (
        .clk     (clk),
        .reset   (reset),
        .port_if (bus_b.slave)
    );

    typedef struct packed {
        logic [63:0] val;
        logic [63:0] cyc;
    } exp_t;

    exp_t        val_q  [2][$];
    exp_t        done_q [2][$];
    int          checks = 0;
    int          errors = 0;
    logic [63:0] cyc = '0;
    int          ready_mode = 0;

    always @(posedge clk) cyc <= cyc + 64'd1;

    // Uniform view of both instances for the monitor and driver.
    logic [1:0]  vld, rdy, dn, bsy;
    logic [63:0] dat [2];
    logic [63:0] sm  [2];
    always_comb begin
        vld[0] = bus_a.out_valid;  vld[1] = bus_b.out_valid;
        rdy[0] = bus_a.out_ready;  rdy[1] = bus_b.out_ready;
        dn[0]  = bus_a.done;       dn[1]  = bus_b.done;
        bsy[0] = bus_a.busy;       bsy[1] = bus_b.busy;
        dat[0] = 64'(bus_a.out_data);
        dat[1] = 64'(bus_b.out_data);
        sm[0]  = 64'(bus_a.sum);
        sm[1]  = 64'(bus_b.sum);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
        end
    endtask

    task automatic flag(input string name);
        checks++;
        errors++;
        $display("FAIL %s t=%0t", name, $time);
    endtask

    task automatic drive_start(input int d, input logic s, input int unsigned lim);
        if (d == 0) begin
            bus_a.start = s;
            bus_a.limit = WA'(lim);
        end else begin
            bus_b.start = s;
            bus_b.limit = WB'(lim);
        end
    endtask

    // Consumer: ready always high (0), random (1), or five stall cycles while
    // instance A offers value 2 (2).
    initial begin
        int stall_left;
        logic r;
        stall_left      = 5;
        bus_a.out_ready = 1'b1;
        bus_b.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            r = 1'b1;
            if (ready_mode == 1) begin
                r = 1'($urandom_range(0, 1));
            end else if (ready_mode == 2) begin
                if (vld[0] && dat[0] == 64'd2 && stall_left > 0) begin
                    r = 1'b0;
                    stall_left--;
                end
            end else begin
                stall_left = 5;
            end
            bus_a.out_ready = r;
            bus_b.out_ready = r;
        end
    end

    // Monitor: pops expectations on handshakes and done pulses.
    logic [1:0]  prev_stall = '0;
    logic [63:0] prev_dat [2];

    task automatic monitor_one(input int d);
        exp_t e;
        if (prev_stall[d]) begin
            check("stall_hold_valid", 64'(vld[d]), 64'd1);
            check("stall_hold_data", dat[d], prev_dat[d]);
        end
        if (!vld[d]) check("data_zero_when_invalid", dat[d], 64'd0);
        if (vld[d] && rdy[d]) begin
            if (val_q[d].size() == 0) begin
                flag($sformatf("unexpected_value dut=%0d data=%0d", d, dat[d]));
            end else begin
                e = val_q[d].pop_front();
                check($sformatf("out_data dut=%0d", d), dat[d], e.val);
                if (e.cyc != NO_T) check($sformatf("valid_cycle dut=%0d", d), cyc, e.cyc);
            end
        end
        prev_stall[d] = vld[d] && !rdy[d];
        prev_dat[d]   = dat[d];
        if (dn[d]) begin
            if (done_q[d].size() == 0) begin
                flag($sformatf("unexpected_done dut=%0d", d));
            end else begin
                e = done_q[d].pop_front();
                check($sformatf("values_left_at_done dut=%0d", d), 64'(val_q[d].size()), 64'd0);
                check($sformatf("sum_at_done dut=%0d", d), sm[d], e.val);
                if (e.cyc != NO_T) check($sformatf("done_cycle dut=%0d", d), cyc, e.cyc);
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_stall = '0;
            end else begin
                for (int d = 0; d < 2; d++) monitor_one(d);
            end
        end
    end

    // One run: expected values are the multiples k*step below limit
    // (limit < 2^width, so the overflow stop lands on the same set).
    task automatic run(input int d, input int unsigned lim, input int rmode);
        longint unsigned w, s, n, t0, exp_sum;
        exp_t e;
        w = (d == 0) ? WA : WB;
        s = (d == 0) ? SA : SB;
        n = (64'(lim) + s - 1) / s;
        exp_sum = SUM_ON ? (s * n * (n - 1) / 2) : 0;
        ready_mode = rmode;
        @(posedge clk);
        #1;
        drive_start(d, 1'b1, lim);
        t0 = cyc;
        for (longint unsigned k = 0; k < n; k++) begin
            e.val = k * s;
            e.cyc = (rmode == 0) ? (t0 + 2 + 3 * k) : NO_T;
            val_q[d].push_back(e);
        end
        e.val = exp_sum;
        if (rmode != 0)  e.cyc = NO_T;
        else if (n == 0) e.cyc = t0 + 2;
        else             e.cyc = t0 + 2 + 3 * (n - 1) + ((((n * s) >> w) != 0) ? 2 : 3);
        done_q[d].push_back(e);
        // Start held into CMP with a new limit: must be ignored.
        @(posedge clk);
        #1;
        drive_start(d, 1'b1, $urandom);
        @(posedge clk);
        #1;
        drive_start(d, 1'b0, $urandom);
        for (int i = 0; i < 4000 && done_q[d].size() != 0; i++) @(posedge clk);
        if (done_q[d].size() != 0) begin
            flag($sformatf("run_timeout dut=%0d limit=%0d", d, lim));
            val_q[d].delete();
            done_q[d].delete();
        end
        @(negedge clk);
        check($sformatf("idle_after_run dut=%0d", d), 64'(bsy[d]), 64'd0);
        check($sformatf("sum_held_idle dut=%0d", d), sm[d], exp_sum);
    endtask

    // Reset while A offers value 5: run aborts, no done, outputs clear.
    task automatic reset_mid_run();
        longint unsigned t0;
        bit found;
        exp_t e;
        ready_mode = 0;
        @(posedge clk);
        #1;
        drive_start(0, 1'b1, 10);
        t0 = cyc;
        for (longint unsigned k = 0; k < 5; k++) begin
            e.val = k;
            e.cyc = t0 + 2 + 3 * k;
            val_q[0].push_back(e);
        end
        @(posedge clk);
        #1;
        drive_start(0, 1'b0, 0);
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(posedge clk);
            #1;
            if (vld[0] && dat[0] == 64'd5) found = 1'b1;
        end
        if (!found) flag("reset_target_not_reached");
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("abort_valid", 64'(vld[0]), 64'd0);
        check("abort_data", dat[0], 64'd0);
        check("abort_busy", 64'(bsy[0]), 64'd0);
        check("abort_done", 64'(dn[0]), 64'd0);
        check("abort_sum", sm[0], 64'd0);
        check("abort_values_consumed", 64'(val_q[0].size()), 64'd0);
        val_q[0].delete();
        repeat (6) @(posedge clk);
    endtask

    initial begin
        reset = 1'b1;
        drive_start(0, 1'b0, 0);
        drive_start(1, 1'b0, 0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("rst_valid dut=%0d", d), 64'(vld[d]), 64'd0);
            check($sformatf("rst_data dut=%0d", d), dat[d], 64'd0);
            check($sformatf("rst_busy dut=%0d", d), 64'(bsy[d]), 64'd0);
            check($sformatf("rst_done dut=%0d", d), 64'(dn[d]), 64'd0);
            check($sformatf("rst_sum dut=%0d", d), sm[d], 64'd0);
        end

        run(0, 10, 0);
        run(0, 0, 0);
        run(0, 4, 2);
        run(1, 15, 0);
        run(1, 0, 0);
        run(1, 13, 0);
        run(1, 1, 0);
        reset_mid_run();
        run(0, 3, 0);
        run(0, 255, 0);
        repeat (12) run(0, $urandom_range(0, 40), int'($urandom_range(0, 1)));
        repeat (8)  run(1, $urandom_range(0, 15), int'($urandom_range(0, 1)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog_expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/count_seq_unit.md
COUNT_SEQ_UNIT -- requirements
Module: count_seq_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the counter and limit width in bits (legal values 2..32).
REQ-002 SHALL have parameter STEP, default 1, giving the counter increment per emitted value (legal values 1..2^WIDTH-1).
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port start, input, 1 bit: run request, sampled only in IDLE.
REQ-006 SHALL have port limit, input, WIDTH bits: exclusive upper bound, captured on the accepted start.
REQ-007 SHALL have port out_ready, input, 1 bit: consumer ready.
REQ-008 SHALL have port out_valid, output, 1 bit: out_data holds a valid count.
REQ-009 SHALL have port out_data, output, WIDTH bits: current count value.
REQ-010 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-011 SHALL have port done, output, 1 bit: one-cycle pulse at end of run.
REQ-012 SHALL have port sum, output, 2*WIDTH bits: running sum of emitted values.

Function
REQ-013 SHALL implement the FSM states IDLE, CMP, OUT, INC and DONE, held in a registered state with combinational next-state and output logic.
REQ-014 In IDLE, when start=1, SHALL capture limit into lim_r, clear the counter A to 0 and the sum to 0, and go to CMP; when start=0, SHALL stay in IDLE.
REQ-015 In CMP, SHALL go to OUT if A < lim_r (unsigned compare), else go to DONE.
REQ-016 In OUT, SHALL drive out_valid=1 and out_data=A; SHALL go to INC on the cycle where out_valid and out_ready are both 1; otherwise SHALL hold in OUT with A and out_data stable.
REQ-017 In INC, SHALL load A with (A+STEP) mod 2^WIDTH; SHALL go to DONE if that addition carries out of WIDTH bits, else go to CMP.
REQ-018 In DONE, SHALL assert done=1 for exactly one cycle, then go to IDLE.
REQ-019 Timing with out_ready held at 1: first out_valid SHALL assert 2 cycles after the start-accept edge; subsequent values SHALL follow every 3 cycles.
REQ-020 When limit=0, SHALL assert no out_valid, and done SHALL pulse 2 cycles after the start-accept edge.
REQ-021 start SHALL be ignored while busy=1; a change on limit after capture SHALL have no effect on the running sequence.
REQ-022 out_valid SHALL be 0 and out_data SHALL be 0 in every state other than OUT.
REQ-023 Illegal state encodings SHALL return to IDLE on the next cycle.

Reset
REQ-024 While reset=1 at a rising clk edge, SHALL force state to IDLE and A, lim_r and sum to 0.
REQ-025 After reset, outputs SHALL be out_valid=0, out_data=0, busy=0, done=0, sum=0.
REQ-026 reset SHALL take priority over start, and reset during any state SHALL abort the run without a done pulse.

Configuration
REQ-027 SHALL use the macro COUNT_SEQ_SUM_EN to control the sum feature.
REQ-028 With COUNT_SEQ_SUM_EN defined, on each OUT handshake SHALL update sum to sum + A, zero-extended to 2*WIDTH bits; sum SHALL hold its value through DONE and IDLE until the next accepted start.
REQ-029 Without COUNT_SEQ_SUM_EN, the sum port SHALL remain present and be driven constant 0, and no accumulator register SHALL be synthesised.

Verification
REQ-030 WIDTH=8, STEP=1, limit=10, out_ready=1 -> SHALL emit 0..9, one value every 3 cycles, then done pulse, with sum=45 (sum=0 without the macro).
REQ-031 limit=0 -> SHALL assert no out_valid, done SHALL pulse at start-accept edge +2, and sum SHALL be 0.
REQ-032 limit=4, out_ready low for 5 cycles while out_data=2 -> out_valid and out_data=2 SHALL hold; the sequence SHALL then continue with 3, and sum SHALL end at 6.
REQ-033 WIDTH=4, STEP=6, limit=15 -> SHALL emit 0, 6, 12; the carry in INC SHALL lead to DONE with no wrap value emitted; sum SHALL be 18.
REQ-034 reset asserted in OUT with out_data=5 -> next cycle SHALL show IDLE, all outputs 0 and no done pulse; a start pulse during the run SHALL be ignored.
